aes_round_engine: RTL and testbench

Parametrised, self-sequencing AES encryption core, the successor to the externally round-stepped column-serial AES block. It performs the initial AddRoundKey, all NR rounds and the final round internally, processing COLS columns per cycle. Round keys come from an external key store over a round-index lookup port. Plaintext and ciphertext move over valid/ready handshakes, so the core sits directly between a data FIFO and a key-expansion unit.

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes_col_round.sv | 27 ++
 rtl/aes_round_engine.sv | 133 +++++++++++++
 tb/tb_aes_round_engine.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types, S-box and GF(2^8) helpers for the AES round engine.
// Byte/column order follows FIPS-197 column-major layout.
package aes_pkg;

  typedef logic [0:3][7:0]       word_t;
  typedef logic [0:3][0:3][7:0]  state_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_HOLD
  } fsm_e;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;
  localparam int unsigned COLS_1 = 1;
  localparam int unsigned COLS_2 = 2;
  localparam int unsigned COLS_4 = 4;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic bit cfg_legal(input int unsigned nr,
                                   input int unsigned cols);
    return (nr == NR_128 || nr == NR_192 || nr == NR_256) &&
           (cols == COLS_1 || cols == COLS_2 || cols == COLS_4);
  endfunction

endpackage

// File: rtl/aes_col_round.sv
// One AES column: SubBytes, optional MixColumns, AddRoundKey.
// Input bytes arrive already ShiftRows-selected.
module aes_col_round
  import aes_pkg::*;
(
  input  word_t b_i,
  input  logic  last_i,
  input  word_t k_i,
  output word_t col_o
);

  word_t s;
  word_t m;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      s[r] = sbox(b_i[r]);
    end
    m[0] = mul2(s[0]) ^ mul3(s[1]) ^ s[2] ^ s[3];
    m[1] = s[0] ^ mul2(s[1]) ^ mul3(s[2]) ^ s[3];
    m[2] = s[0] ^ s[1] ^ mul2(s[2]) ^ mul3(s[3]);
    m[3] = mul3(s[0]) ^ s[1] ^ s[2] ^ mul2(s[3]);
  end

  assign col_o = (last_i ? s : m) ^ k_i;

endmodule

// File: rtl/aes_round_engine.sv
// Self-sequencing AES encryption core, COLS columns per cycle.
// Round keys are fetched combinationally through key_rnd/key_in.
module aes_round_engine
  import aes_pkg::*;
#(
  parameter int unsigned NR   = 10,
  parameter int unsigned COLS = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   key_rnd,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  if (!cfg_legal(NR, COLS)) begin : g_bad_cfg
    $error("aes_round_engine: NR must be 10/12/14, COLS 1/2/4");
  end

  fsm_e   state_q, state_d;
  state_t st_q, st_d;
  state_t nx_q, nx_d;
  state_t out_q, out_d;
  logic [3:0] rnd_q, rnd_d;
  logic [1:0] col_q, col_d;

  state_t key_st;
  state_t merged;
  word_t  res [COLS];
  logic   last;
  logic   col_end;

  assign key_st  = key_in;
  assign last    = (rnd_q == 4'(NR));
  assign col_end = (col_q + 2'(COLS - 1)) == 2'd3;

  for (genvar k = 0; k < COLS; k++) begin : g_col
    logic [1:0] j;
    word_t      sh;

    assign j = col_q + 2'(k);

    always_comb begin
      for (int r = 0; r < 4; r++) begin
        sh[r] = st_q[j + 2'(r)][r];
      end
    end

    aes_col_round u_col (
      .b_i    (sh),
      .last_i (last),
      .k_i    (key_st[j]),
      .col_o  (res[k])
    );
  end

  // st stays untouched until the round's last column, so ShiftRows
  // always reads the previous round's state.
  always_comb begin
    merged = nx_q;
    for (int k = 0; k < COLS; k++) begin
      merged[col_q + 2'(k)] = res[k];
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    nx_d    = nx_q;
    out_d   = out_q;
    rnd_d   = rnd_q;
    col_d   = col_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d    = in_data ^ key_in;
          rnd_d   = 4'd1;
          col_d   = 2'd0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        nx_d  = merged;
        col_d = col_q + 2'(COLS);
        if (col_end) begin
          st_d  = merged;
          rnd_d = rnd_q + 4'd1;
          if (last) begin
            out_d   = merged;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      nx_q    <= '0;
      out_q   <= '0;
      rnd_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      nx_q    <= nx_d;
      out_q   <= out_d;
      rnd_q   <= rnd_d;
      col_q   <= col_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = out_q;
  assign key_rnd   = (state_q == S_ROUND) ? rnd_q : 4'd0;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: four configurations against a
// textbook byte-array AES model and FIPS-197 vectors.
module tb_aes_round_engine;

  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PTC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] K3  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   in_valid = '0;
  logic [3:0]   out_ready = '1;
  logic [3:0]   in_ready, out_valid, busy;
  logic [127:0] in_data [4];
  logic [127:0] key_in [4];
  logic [127:0] out_data [4];
  logic [3:0]   key_rnd [4];
  logic [127:0] rk [4][16];
  logic [7:0]   sb [256];

  int nr_of [4]  = '{10, 10, 10, 14};
  int cpr_of [4] = '{4, 2, 1, 4};

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes_round_engine #(
      .NR   (g == 3 ? 14 : 10),
      .COLS (g == 1 ? 2 : (g == 2 ? 4 : 1))
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .key_rnd   (key_rnd[g]),
      .key_in    (key_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
    assign key_in[g] = rk[g][key_rnd[g]];
  end

  task automatic chk(input string nm, input int i,
                     input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, i, act, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sb[x] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input int i, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int k = 0; k < nk; k++) w[k] = key[255 - 32 * k -: 32];
    for (int k = nk; k < 4 * (nr + 1); k++) begin
      t = w[k - 1];
      if (k % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && k % nk == 4) begin
        t = subw(t);
      end
      w[k] = w[k - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      rk[i][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic logic [127:0] enc(input int i, input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int b = 0; b < 16; b++)
      s[b] = pt[127 - 8 * b -: 8] ^ rk[i][0][127 - 8 * b -: 8];
    for (int r = 1; r <= nr_of[i]; r++) begin
      for (int b = 0; b < 16; b++) s[b] = sb[s[b]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[q + 4 * c] = s[q + 4 * ((c + q) % 4)];
      for (int c = 0; c < 4; c++) begin
        a0 = t[4 * c]; a1 = t[4 * c + 1]; a2 = t[4 * c + 2]; a3 = t[4 * c + 3];
        if (r < nr_of[i]) begin
          s[4 * c]     = gm(a0, 2) ^ gm(a1, 3) ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ gm(a1, 2) ^ gm(a2, 3) ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ gm(a2, 2) ^ gm(a3, 3);
          s[4 * c + 3] = gm(a0, 3) ^ a1 ^ a2 ^ gm(a3, 2);
        end else begin
          s[4 * c] = a0; s[4 * c + 1] = a1; s[4 * c + 2] = a2; s[4 * c + 3] = a3;
        end
      end
      for (int b = 0; b < 16; b++) s[b] ^= rk[i][r][127 - 8 * b -: 8];
    end
    for (int b = 0; b < 16; b++) o[127 - 8 * b -: 8] = s[b];
    return o;
  endfunction

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_HOLD} mph_e;
  mph_e         mph [4] = '{M_IDLE, M_IDLE, M_IDLE, M_IDLE};
  int           mt [4];
  int           macc [4];
  int           nacc [4] = '{0, 0, 0, 0};
  logic [127:0] mexp [4];
  int           cyc = 0;

  // Block-level model: accept in idle, busy for NR*4/COLS cycles, hold.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        mph[i] <= M_IDLE;
        mt[i]  <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 4; i++) begin
        case (mph[i])
          M_IDLE: if (in_valid[i]) begin
            mexp[i] <= enc(i, in_data[i]);
            mph[i]  <= M_RUN;
            mt[i]   <= 0;
            macc[i] <= cyc + 1;
            nacc[i] <= nacc[i] + 1;
          end
          M_RUN: begin
            mt[i] <= mt[i] + 1;
            if (mt[i] + 1 == nr_of[i] * cpr_of[i]) mph[i] <= M_HOLD;
          end
          default: if (out_ready[i]) mph[i] <= M_IDLE;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        chk("in_ready", i, 128'(in_ready[i]), 128'(mph[i] == M_IDLE));
        chk("busy", i, 128'(busy[i]), 128'(mph[i] != M_IDLE));
        chk("out_valid", i, 128'(out_valid[i]), 128'(mph[i] == M_HOLD));
        if (mph[i] == M_HOLD) chk("out_data", i, out_data[i], mexp[i]);
        if (mph[i] == M_IDLE) chk("key_rnd_idle", i, 128'(key_rnd[i]), 128'(0));
        if (mph[i] == M_RUN)
          chk("key_rnd", i, 128'(key_rnd[i]), 128'(1 + mt[i] / cpr_of[i]));
      end
    end
  end

  task automatic check_reset_all();
    for (int i = 0; i < 4; i++) begin
      chk("rst_in_ready", i, 128'(in_ready[i]), 128'(1));
      chk("rst_out_valid", i, 128'(out_valid[i]), 128'(0));
      chk("rst_busy", i, 128'(busy[i]), 128'(0));
      chk("rst_key_rnd", i, 128'(key_rnd[i]), 128'(0));
      chk("rst_out_data", i, out_data[i], 128'(0));
    end
  endtask

  task automatic wait_accept(input int i);
    int n0;
    int n;
    n0 = nacc[i];
    n = 0;
    while (nacc[i] == n0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (nacc[i] == n0) chk("accept_timeout", i, 128'(0), 128'(1));
  endtask

  task automatic wait_out_valid(input int i);
    int n;
    n = 0;
    while (!out_valid[i] && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid[i]) chk("out_valid_timeout", i, 128'(0), 128'(1));
  endtask

  task automatic run_block(input int i, input logic [127:0] pt,
                           output logic [127:0] ct, output int lat);
    int n;
    @(posedge clk);
    #1;
    in_valid[i] = 1'b1;
    in_data[i] = pt;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready[i] && n < 100);
    @(posedge clk);
    #1;
    in_valid[i] = 1'b0;
    lat = 0;
    while (!out_valid[i] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid[i]) chk("latency_timeout", i, 128'(0), 128'(1));
    ct = out_data[i];
    @(posedge clk);
    #1;
  endtask

  logic [127:0] ct;
  int lat;
  int r0;
  int acc [3];

  initial begin
    for (int i = 0; i < 4; i++) in_data[i] = '0;
    build_sbox();
    expand(0, {KB, 128'h0}, 4);
    expand(1, {K1, 128'h0}, 4);
    expand(2, {K1, 128'h0}, 4);
    expand(3, K3, 8);

    chk("sbox_00", 0, 128'(sb[0]), 128'h63);
    chk("sbox_53", 0, 128'(sb[8'h53]), 128'hed);
    chk("rk10_appB", 0, rk[0][10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_appB", 0, enc(0, PTB), CTB);
    chk("model_c1", 1, enc(1, PTC), CT1);
    chk("model_c3", 3, enc(3, PTC), CT3);

    @(posedge clk);
    #1;
    check_reset_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_block(0, PTB, ct, lat);
    chk("t1_ct", 0, ct, CTB);
    chk("t1_lat", 0, 128'(lat), 128'(40));
    run_block(1, PTC, ct, lat);
    chk("t2_ct_c2", 1, ct, CT1);
    chk("t2_lat_c2", 1, 128'(lat), 128'(20));
    run_block(2, PTC, ct, lat);
    chk("t2_ct_c4", 2, ct, CT1);
    chk("t2_lat_c4", 2, 128'(lat), 128'(10));
    run_block(3, PTC, ct, lat);
    chk("t3_ct", 3, ct, CT3);
    chk("t3_lat", 3, 128'(lat), 128'(56));

    out_ready[0] = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b1;
    in_data[0] = PTB;
    wait_accept(0);
    in_data[0] = PTC;
    wait_out_valid(0);
    repeat (15) @(posedge clk);
    #1;
    chk("t4_hold_data", 0, out_data[0], CTB);
    chk("t4_hold_valid", 0, 128'(out_valid[0]), 128'(1));
    chk("t4_hold_ready", 0, 128'(in_ready[0]), 128'(0));
    out_ready[0] = 1'b1;
    r0 = cyc;
    wait_accept(0);
    chk("t4_accept_gap", 0, 128'(macc[0] - r0), 128'(2));
    in_valid[0] = 1'b0;
    wait_out_valid(0);
    @(posedge clk);
    #1;

    @(posedge clk);
    #1;
    in_valid[0] = 1'b1;
    in_data[0] = PTC;
    wait_accept(0);
    in_valid[0] = 1'b0;
    repeat (17) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_all();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_block(0, PTB, ct, lat);
    chk("t5_ct", 0, ct, CTB);
    chk("t5_lat", 0, 128'(lat), 128'(40));

    @(posedge clk);
    #1;
    in_valid[0] = 1'b1;
    in_data[0] = PTB;
    for (int k = 0; k < 3; k++) begin
      wait_accept(0);
      acc[k] = macc[0];
      in_data[0] = (k == 0) ? PTC : 128'h0;
    end
    in_valid[0] = 1'b0;
    chk("t6_gap0", 0, 128'(acc[1] - acc[0]), 128'(42));
    chk("t6_gap1", 0, 128'(acc[2] - acc[1]), 128'(42));
    repeat (50) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
